// File: rtl/ps2_pkg.sv
// ps2_pkg: FSM states and constants shared by the PS/2 frame receiver.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_DATA_BITS    = 8;
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: synchronises a raw pin, deglitches it and flags each filtered 1->0 edge.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic i_line,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_level;
    logic [CW-1:0]          r_cnt;
    logic                   w_diff;
    logic                   w_flip;
    assign w_diff = r_sync[SYNC_STAGES-1] != r_level;
    assign w_flip = w_diff && (r_cnt == CW'(FILTER_LEN - 1));
    // Idle PS/2 clock is high, so starting high avoids a spurious fall out of reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_sync  <= '1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            o_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_cnt   <= (w_diff && !w_flip) ? r_cnt + CW'(1) : '0;
            r_level <= w_flip ? ~r_level : r_level;
            o_fall  <= w_flip && r_level;
        end
    end
endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: deserialises PS/2 frames into checked scan-code bytes.
// Optional prefix (E0/F0) tracking is enabled by defining PS2_PREFIX_TRACK_EN.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 63000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy,
    output logic [8:0] key_code,
    output logic       is_break
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);
    ps2_state_t             r_state;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic [BW-1:0]          r_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic [TW-1:0]          r_to;
    logic                   w_fall;
    logic                   w_dat;
`ifdef PS2_PREFIX_TRACK_EN
    logic                   r_ext;
    logic                   r_brk;
`endif
    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .resetN (resetN),
        .i_line (ps2_clk),
        .o_fall (w_fall)
    );
    assign w_dat = r_dat_sync[SYNC_STAGES-1];
    assign busy  = r_state != IDLE;
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_dat_sync <= '1;
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to       <= '0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            key_code   <= '0;
            is_break   <= 1'b0;
`ifdef PS2_PREFIX_TRACK_EN
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
`endif
        end else begin
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_dat};
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            r_to       <= (r_state == IDLE || w_fall) ? '0 : (r_to == TO_MAX) ? r_to : r_to + TW'(1);
            // A fall always beats a timeout expiring in the same cycle.
            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        r_state <= w_dat ? IDLE : DATA;
                        r_cnt   <= '0;
                    end
                    DATA: begin
                        r_shift[r_cnt] <= w_dat;
                        r_cnt          <= r_cnt + BW'(1);
                        r_state        <= (r_cnt == BW'(PS2_DATA_BITS - 1)) ? PARITY : DATA;
                    end
                    PARITY: begin
                        r_par   <= w_dat;
                        r_state <= STOP;
                    end
                    default: begin
                        r_state <= IDLE;
                        if (!w_dat || !(^{r_shift, r_par})) begin
                            frame_err  <= !w_dat;
                            parity_err <= w_dat;
`ifdef PS2_PREFIX_TRACK_EN
                            r_ext      <= 1'b0;
                            r_brk      <= 1'b0;
`endif
                        end else begin
                            data <= r_shift;
`ifdef PS2_PREFIX_TRACK_EN
                            if (r_shift == PS2_EXT_PREFIX) r_ext <= 1'b1;
                            else if (r_shift == PS2_BREAK_PREFIX) r_brk <= 1'b1;
                            else begin
                                valid    <= 1'b1;
                                key_code <= {r_ext, r_shift};
                                is_break <= r_brk;
                                r_ext    <= 1'b0;
                                r_brk    <= 1'b0;
                            end
`else
                            valid    <= 1'b1;
                            key_code <= {1'b0, r_shift};
`endif
                        end
                    end
                endcase
            end else if (r_state != IDLE && r_to == TO_MAX) begin
                frame_err <= 1'b1;
                r_state   <= IDLE;
`ifdef PS2_PREFIX_TRACK_EN
                r_ext     <= 1'b0;
                r_brk     <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Receives raw PS/2 keyboard traffic (PS2_CLK, PS2_DAT pins) and delivers validated scan-code bytes, one per frame, to keyboard_block.
- Synchronises and deglitches the PS/2 clock, then deserialises 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Checks parity, stop bit and inter-edge timeout, and emits single-cycle result pulses in the pixel clock domain.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchroniser on both pin inputs.
- FILTER_LEN, 4: consecutive equal synchronised clock samples required before the filtered clock level changes.
- TIMEOUT_CYCLES, 63000: idle clocks allowed between falling edges inside a frame. This is about 2 ms at the pixel clock.

Ports:
- clk  in  1  system (pixel) clock from clock_divider.
- resetN  in  1  synchronous reset, active low.
- ps2_clk  in  1  raw PS2_CLK pin, asynchronous.
- ps2_dat  in  1  raw PS2_DAT pin, asynchronous.
- data  out  8  last received byte.
- valid  out  1  one-cycle pulse: data/key_code updated.
- parity_err  out  1  one-cycle pulse: frame dropped, bad parity.
- frame_err  out  1  one-cycle pulse: frame dropped, bad stop bit or timeout.
- busy  out  1  high while a frame is in progress (state != IDLE).
- key_code  out  9  {ext, byte}; ext meaningful only with the optional feature.
- is_break  out  1  break flag accompanying key_code.

Behaviour:
- Reset: all outputs are 0 and state is IDLE.
  - Asserting resetN low mid-frame aborts the frame on the next clock edge.
  - No error pulse is emitted for a reset abort.
- Input path:
  - Both pins pass through SYNC_STAGES flops.
  - Filtered clock level flips on the edge where FILTER_LEN consecutive synced samples differ from it.
  - fall = registered 1->0 transition of the filtered level, one cycle wide.
  - Data is sampled from the synced ps2_dat on the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, fall with dat=0: go to DATA, clear bit counter. With dat=1 stay in IDLE; no error.
  - DATA: on each fall shift dat into bit[cnt], LSB first. After the 8th bit go to PARITY.
  - PARITY: on fall latch the parity bit, go to STOP.
  - STOP, on fall:
    - dat=0 gives a frame_err pulse.
    - Otherwise, if XOR of 8 data bits and parity bit != 1, a parity_err pulse.
    - Otherwise accept the byte.
    - Always return to IDLE.
    - frame_err takes precedence when both conditions hold.
- Accept: data and valid are registered the cycle after the stop-bit fall cycle.
  - Latency from the pin falling edge to valid high is exactly SYNC_STAGES+FILTER_LEN+1 clocks.
  - data holds its value until the next accept.
- Timeout:
  - Counter clears on every fall and in IDLE.
  - In a non-IDLE state, when the counter reaches TIMEOUT_CYCLES-1: frame_err pulse, go to IDLE, discard partial bits.
  - Counter width is $clog2(TIMEOUT_CYCLES); it saturates, never wraps.
- Simultaneous events: a timeout expiring on the same cycle as a fall is won by the fall, and the counter restarts.
- Without the optional feature: every accepted byte gives key_code={1'b0,data} and is_break=0.

Optional Feature:
PS2_PREFIX_TRACK_EN
- Defined:
  - Accepted 0xE0 sets the internal ext flag; accepted 0xF0 sets the internal brk flag.
  - Neither prefix pulses valid.
  - The next non-prefix byte pulses valid with key_code={ext,byte} and is_break=brk, then clears both flags.
  - parity_err, frame_err or timeout also clears both flags.
- Undefined:
  - Prefix bytes are ordinary bytes and each one pulses valid.
  - key_code[8] and is_break are tied to 0.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - PS2_EXT_PREFIX=8'hE0 and PS2_BREAK_PREFIX=8'hF0;
  - PS2_DATA_BITS=8.
- Sub-module ps2_line_filter (synchroniser, glitch filter, fall detect), instantiated once for ps2_clk.
- ps2_dat uses a bare synchroniser of the same depth.

Test Plan:
- Frame 0x1C, parity 0, stop 1 -> one valid; data=8'h1C, key_code=9'h01C; valid exactly SYNC_STAGES+FILTER_LEN+1 clocks after the stop-bit fall.
- Frame 0x1C with parity 1 -> parity_err pulse, no valid, data keeps its previous value.
- Frame 0x6B with stop bit 0 -> frame_err pulse only (no parity_err), no valid, busy low afterwards.
- Stop clocking after 5 data bits; wait TIMEOUT_CYCLES -> one frame_err, busy=0. Then send a good 0x6B -> valid with data=8'h6B.
- With FILTER_LEN=4, a 2-clock low glitch on ps2_clk while IDLE and ps2_dat=0 -> no state change, busy stays 0.
- Sequence E0, F0, 6B (parity 0, 1, 0):
  - with PS2_PREFIX_TRACK_EN -> single valid, key_code=9'h16B, is_break=1;
  - without it -> three valids with data E0, F0, 6B.
